tohost_sig_dumper: RTL and testbench

//  Synthesizable successor to the bench-side TOHOST watcher: snoops CPU data-bus AHB-Lite writes for a TOHOST exit code,

---
 rtl/tohost_sig_dumper_pkg.sv | 29 ++
 rtl/tohost_sig_dumper_snoop.sv | 67 ++++++
 rtl/tohost_sig_dumper.sv | 184 ++++++++++++++++++
 tb/tb_tohost_sig_dumper.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tohost_sig_dumper_pkg.sv
// Shared constants and types for the TOHOST watcher and signature dumper.
// Chip address map defaults, AHB transfer codes and dump FSM states.
package tohost_sig_dumper_pkg;

   localparam logic [31:0] TOHOST_ADDR_DEF = 32'h8000_1000;
   localparam logic [31:0] DUMP_BGN_DEF    = 32'h8000_2000;
   localparam logic [31:0] DUMP_END_DEF    = 32'h8000_2100;
   localparam logic [31:0] PASS_CODE_DEF   = 32'h0000_0001;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_DATA = 3'd2,
      ST_PUSH = 3'd3,
      ST_DONE = 3'd4
   } dump_state_e;

   function automatic logic [31:0] word_after(input logic [31:0] a);
      return a + 32'd4;
   endfunction

endpackage

// File: rtl/tohost_sig_dumper_snoop.sv
// Passive AHB-Lite write snooper for the TOHOST exit word.
// Raises hit during the data phase of an honoured exit write.
module tohost_snoop
   import tohost_sig_dumper_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
   parameter logic [31:0] PASS_CODE   = PASS_CODE_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        s_hsel,
   input  logic [1:0]  s_htrans,
   input  logic        s_hwrite,
   input  logic [2:0]  s_hsize,
   input  logic [31:0] s_haddr,
   input  logic [31:0] s_hwdata,
   input  logic        s_hready,
   output logic        hit,
   output logic [31:0] code,
   output logic        pass
);

   logic        match_q, match_d;
   logic [31:0] code_q, code_d;
   logic        pass_q, pass_d;
   logic        active;

   // A transfer is active for NONSEQ and SEQ, i.e. HTRANS[1] set.
   assign active = (s_htrans == HTRANS_NONSEQ) || (s_htrans == HTRANS_SEQ);

   // Only an exit write (bit0 set) in an idle dumper counts as a hit.
   assign hit = match_q & s_hready & s_hwdata[0] & en;

   // Address phase tracking and exit-code capture.
   always_comb begin
      match_d = match_q;
      code_d  = code_q;
      pass_d  = pass_q;
      if (s_hready) begin
         match_d = s_hsel & active & s_hwrite &
                   (s_hsize == HSIZE_WORD) &
                   (s_haddr == TOHOST_ADDR);
      end
      if (hit) begin
         code_d = s_hwdata;
         pass_d = (s_hwdata == PASS_CODE);
      end
   end

   // Snoop state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         match_q <= 1'b0;
         code_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         match_q <= match_d;
         code_q  <= code_d;
         pass_q  <= pass_d;
      end
   end

   assign code = code_q;
   assign pass = pass_q;

endmodule

// File: rtl/tohost_sig_dumper.sv
// TOHOST watcher plus signature dumper: reads [DUMP_BGN, DUMP_END)
// over a single-outstanding AHB-Lite master and streams it out.
module tohost_sig_dumper
   import tohost_sig_dumper_pkg::*;
#(
   parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF,
   parameter logic [31:0] DUMP_BGN    = DUMP_BGN_DEF,
   parameter logic [31:0] DUMP_END    = DUMP_END_DEF,
   parameter logic [31:0] PASS_CODE   = PASS_CODE_DEF
) (
   input  logic        CLK,
   input  logic        RES_N,
   input  logic        S_HSEL,
   input  logic [1:0]  S_HTRANS,
   input  logic        S_HWRITE,
   input  logic [2:0]  S_HSIZE,
   input  logic [31:0] S_HADDR,
   input  logic [31:0] S_HWDATA,
   input  logic        S_HREADY,
   output logic [1:0]  M_HTRANS,
   output logic [31:0] M_HADDR,
   output logic [2:0]  M_HSIZE,
   output logic        M_HWRITE,
   input  logic        M_HREADY,
   input  logic        M_HRESP,
   input  logic [31:0] M_HRDATA,
   output logic        SIG_VALID,
   output logic [31:0] SIG_DATA,
   output logic        SIG_LAST,
   input  logic        SIG_READY,
   output logic        TOHOST_HIT,
   output logic [31:0] TOHOST_CODE,
   output logic        TOHOST_PASS,
   output logic        DUMP_BUSY,
   output logic        DUMP_DONE,
   output logic        DUMP_ERR
);

   dump_state_e state_q, state_d;
   logic [31:0] ptr_q, ptr_d;
   logic [1:0]  htrans_q, htrans_d;
   logic [31:0] haddr_q, haddr_d;
   logic [31:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic        last_q, last_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        idle;
   logic        trig;
   logic [31:0] ptr_nxt;

   assign idle    = (state_q == ST_IDLE);
   assign ptr_nxt = word_after(ptr_q);

   tohost_snoop #(
      .TOHOST_ADDR (TOHOST_ADDR),
      .PASS_CODE   (PASS_CODE)
   ) u_snoop (
      .clk      (CLK),
      .rst_n    (RES_N),
      .en       (idle),
      .s_hsel   (S_HSEL),
      .s_htrans (S_HTRANS),
      .s_hwrite (S_HWRITE),
      .s_hsize  (S_HSIZE),
      .s_haddr  (S_HADDR),
      .s_hwdata (S_HWDATA),
      .s_hready (S_HREADY),
      .hit      (trig),
      .code     (TOHOST_CODE),
      .pass     (TOHOST_PASS)
   );

   // Dump sequencing: one read, one push, repeat until the end address.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      htrans_d = htrans_q;
      haddr_d  = haddr_q;
      data_d   = data_q;
      valid_d  = valid_q;
      last_d   = last_q;
      done_d   = done_q;
      err_d    = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (trig) begin
               if (DUMP_BGN == DUMP_END) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = ST_ADDR;
                  ptr_d    = DUMP_BGN;
                  htrans_d = HTRANS_NONSEQ;
                  haddr_d  = DUMP_BGN;
               end
            end
         end
         ST_ADDR: begin
            if (M_HREADY) begin
               state_d  = ST_DATA;
               htrans_d = HTRANS_IDLE;
            end
         end
         ST_DATA: begin
            if (M_HRESP) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
               done_d  = 1'b1;
            end else if (M_HREADY) begin
               state_d = ST_PUSH;
               data_d  = M_HRDATA;
               valid_d = 1'b1;
               last_d  = (ptr_nxt == DUMP_END);
            end
         end
         ST_PUSH: begin
            if (SIG_READY) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               ptr_d   = ptr_nxt;
               if (ptr_nxt == DUMP_END) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = ST_ADDR;
                  htrans_d = HTRANS_NONSEQ;
                  haddr_d  = ptr_nxt;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_ADDR) ||
               (state_d == ST_DATA) ||
               (state_d == ST_PUSH);
   end

   // Dump state and registered bus/stream outputs.
   always_ff @(posedge CLK or negedge RES_N) begin
      if (!RES_N) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         htrans_q <= HTRANS_IDLE;
         haddr_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         htrans_q <= htrans_d;
         haddr_q  <= haddr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         last_q   <= last_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign M_HTRANS   = htrans_q;
   assign M_HADDR    = haddr_q;
   assign M_HSIZE    = HSIZE_WORD;
   assign M_HWRITE   = 1'b0;
   assign SIG_VALID  = valid_q;
   assign SIG_DATA   = data_q;
   assign SIG_LAST   = last_q;
   assign TOHOST_HIT = trig;
   assign DUMP_BUSY  = busy_q;
   assign DUMP_DONE  = done_q;
   assign DUMP_ERR   = err_q;

endmodule

// File: tb/tb_tohost_sig_dumper.sv
// Scoreboard bench for tohost_sig_dumper: a memory slave model on the
// master port, a stream monitor popping expected words from a queue.
module tb_tohost_sig_dumper;
   import tohost_sig_dumper_pkg::*;

   localparam logic [31:0] TOHOST = 32'h8000_1000;
   localparam logic [31:0] BGN    = 32'h8000_2000;
   localparam logic [31:0] END_A  = 32'h8000_2010;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic s_hsel = 1'b0;
   logic [1:0] s_htrans = HTRANS_IDLE;
   logic s_hwrite = 1'b0;
   logic [2:0] s_hsize = 3'b000;
   logic [31:0] s_haddr = '0;
   logic [31:0] s_hwdata = '0;
   logic s_hready = 1'b1;
   logic m_hready = 1'b1;
   logic m_hresp = 1'b0;
   logic [31:0] m_hrdata = '0;
   logic sig_ready = 1'b1;

   logic [1:0] a_htrans;
   logic [31:0] a_haddr;
   logic [2:0] a_hsize;
   logic a_hwrite, a_valid, a_last, a_hit, a_pass;
   logic a_busy, a_done, a_err;
   logic [31:0] a_data, a_code;

   logic [1:0] b_htrans;
   logic [31:0] b_haddr;
   logic [2:0] b_hsize;
   logic b_hwrite, b_valid, b_last, b_hit, b_pass;
   logic b_busy, b_done, b_err;
   logic [31:0] b_data, b_code;

   always #5 clk = ~clk;

   tohost_sig_dumper #(
      .TOHOST_ADDR (TOHOST),
      .DUMP_BGN    (BGN),
      .DUMP_END    (END_A),
      .PASS_CODE   (32'h1)
   ) dut_a (
      .CLK (clk), .RES_N (rst_n),
      .S_HSEL (s_hsel), .S_HTRANS (s_htrans),
      .S_HWRITE (s_hwrite), .S_HSIZE (s_hsize),
      .S_HADDR (s_haddr), .S_HWDATA (s_hwdata),
      .S_HREADY (s_hready),
      .M_HTRANS (a_htrans), .M_HADDR (a_haddr),
      .M_HSIZE (a_hsize), .M_HWRITE (a_hwrite),
      .M_HREADY (m_hready), .M_HRESP (m_hresp),
      .M_HRDATA (m_hrdata),
      .SIG_VALID (a_valid), .SIG_DATA (a_data),
      .SIG_LAST (a_last), .SIG_READY (sig_ready),
      .TOHOST_HIT (a_hit), .TOHOST_CODE (a_code),
      .TOHOST_PASS (a_pass), .DUMP_BUSY (a_busy),
      .DUMP_DONE (a_done), .DUMP_ERR (a_err)
   );

   tohost_sig_dumper #(
      .TOHOST_ADDR (TOHOST),
      .DUMP_BGN    (BGN),
      .DUMP_END    (BGN),
      .PASS_CODE   (32'h1)
   ) dut_b (
      .CLK (clk), .RES_N (rst_n),
      .S_HSEL (s_hsel), .S_HTRANS (s_htrans),
      .S_HWRITE (s_hwrite), .S_HSIZE (s_hsize),
      .S_HADDR (s_haddr), .S_HWDATA (s_hwdata),
      .S_HREADY (s_hready),
      .M_HTRANS (b_htrans), .M_HADDR (b_haddr),
      .M_HSIZE (b_hsize), .M_HWRITE (b_hwrite),
      .M_HREADY (1'b1), .M_HRESP (1'b0),
      .M_HRDATA (32'h0),
      .SIG_VALID (b_valid), .SIG_DATA (b_data),
      .SIG_LAST (b_last), .SIG_READY (1'b1),
      .TOHOST_HIT (b_hit), .TOHOST_CODE (b_code),
      .TOHOST_PASS (b_pass), .DUMP_BUSY (b_busy),
      .DUMP_DONE (b_done), .DUMP_ERR (b_err)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t exp_q[$];

   logic [31:0] mem [4];
   int stall = 0;
   int err_idx = -1;
   int rdy_word = -1;
   bit dphase = 1'b0;
   logic [31:0] daddr = '0;
   int dwait = 0;
   int aw = 0;
   bit errst = 1'b0;
   int rwait = 0;
   int acc_cnt = 0;
   int nacc_addr = 0;
   logic [31:0] stall_addr = '0;
   logic [31:0] hold_data = '0;
   bit prev_acc = 1'b0;
   logic prev_last = 1'b0;

   // Slave and sink drivers, updated just after each rising edge.
   initial begin : drive
      int idx;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            m_hready  = 1'b1;
            m_hresp   = 1'b0;
            m_hrdata  = '0;
            sig_ready = 1'b1;
         end else begin
            if (dphase) begin
               idx = int'((daddr - BGN) >> 2);
               if (dwait > 0) begin
                  m_hready = 1'b0;
                  m_hresp  = 1'b0;
                  dwait--;
               end else if (idx == err_idx) begin
                  m_hresp = 1'b1;
                  m_hready = errst;
                  errst = 1'b1;
               end else begin
                  m_hready = 1'b1;
                  m_hresp  = 1'b0;
                  m_hrdata = mem[idx[1:0]];
               end
            end else begin
               m_hresp  = 1'b0;
               m_hready = !(a_htrans == HTRANS_NONSEQ && aw < stall);
            end
            sig_ready = !(a_valid && acc_cnt == rdy_word && rwait < 10);
            if (!sig_ready) rwait++;
         end
      end
   end

   // Bus bookkeeping and stream scoreboard, on the falling edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            dphase   = 1'b0;
            aw       = 0;
            dwait    = 0;
            errst    = 1'b0;
            prev_acc = 1'b0;
            continue;
         end
         if (dphase && m_hready) dphase = 1'b0;
         if (a_htrans == HTRANS_NONSEQ) begin
            if (aw > 0) chk("haddr_stable", a_haddr, stall_addr);
            stall_addr = a_haddr;
            if (m_hready) begin
               chk("haddr", a_haddr, BGN + 32'(4 * nacc_addr));
               nacc_addr++;
               dphase = 1'b1;
               daddr  = a_haddr;
               dwait  = stall;
               aw     = 0;
               errst  = 1'b0;
            end else begin
               aw++;
            end
         end
         if (prev_acc)
            chk("nonseq_after_accept", a_htrans,
                prev_last ? HTRANS_IDLE : HTRANS_NONSEQ);
         prev_acc = 1'b0;
         if (a_valid) begin
            chk("idle_while_valid", a_htrans, HTRANS_IDLE);
            if (sig_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sig_extra: got %0h expected no word", a_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("sig_data", a_data, e.data);
                  chk("sig_last", a_last, e.last);
               end
               acc_cnt++;
               prev_acc  = 1'b1;
               prev_last = a_last;
            end else begin
               if (rwait > 1) chk("sig_hold", a_data, hold_data);
               hold_data = a_data;
            end
         end
      end
   end

   task automatic do_reset(input int st, input int ei, input int rw);
      rst_n = 1'b0;
      exp_q.delete();
      stall     = st;
      err_idx   = ei;
      rdy_word  = rw;
      acc_cnt   = 0;
      rwait     = 0;
      nacc_addr = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push_words(input int n, input bit with_last);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.data = mem[i];
         e.last = with_last && (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic ahb_write(input logic [31:0] addr,
                            input logic [2:0] size,
                            input logic [31:0] data,
                            output logic hit_a,
                            output logic hit_b);
      @(posedge clk);
      #1;
      s_hsel   = 1'b1;
      s_htrans = HTRANS_NONSEQ;
      s_hwrite = 1'b1;
      s_hsize  = size;
      s_haddr  = addr;
      @(posedge clk);
      #1;
      s_hsel   = 1'b0;
      s_htrans = HTRANS_IDLE;
      s_hwrite = 1'b0;
      s_hwdata = data;
      @(negedge clk);
      hit_a = a_hit;
      hit_b = b_hit;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!a_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, a_done, 1);
   endtask

   logic ha, hb;

   initial begin : main
      for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);

      do_reset(0, -1, -1);
      #1;
      chk("reset_flags",
          {a_valid, a_last, a_hit, a_pass, a_busy, a_done, a_err,
           a_hwrite, a_htrans, a_hsize},
          {7'b0, 1'b0, HTRANS_IDLE, 3'b010});
      chk("reset_haddr", a_haddr, 0);
      chk("reset_data_code", {a_data, a_code}, 0);

      // Pass code, plain dump of four words.
      push_words(4, 1'b1);
      ahb_write(TOHOST, HSIZE_WORD, 32'h1, ha, hb);
      chk("t1_hit", ha, 1);
      chk("t1_b_hit", hb, 1);
      @(negedge clk);
      chk("t1_nonseq_t1", a_htrans, HTRANS_NONSEQ);
      chk("t1_busy", a_busy, 1);
      chk("t1_code_pass", {a_code, a_pass}, {32'h1, 1'b1});
      chk("t1_b_done", b_done, 1);
      chk("t1_b_busy_valid", {b_busy, b_valid}, 0);
      @(negedge clk);
      chk("t1_no_valid_t2", a_valid, 0);
      @(negedge clk);
      chk("t1_valid_t3", a_valid, 1);
      wait_done("t1_done", 200);
      chk("t1_words", acc_cnt, 4);
      chk("t1_queue_empty", exp_q.size(), 0);
      chk("t1_err_busy", {a_err, a_busy}, 0);
      chk("t1_b_never_valid", {b_valid, b_err}, 0);

      // Byte write, then a word write with bit0 clear.
      do_reset(0, -1, -1);
      ahb_write(TOHOST, 3'b000, 32'h1, ha, hb);
      chk("t2_byte_no_hit", ha, 0);
      ahb_write(TOHOST, HSIZE_WORD, 32'h0, ha, hb);
      chk("t2_zero_no_hit", ha, 0);
      repeat (5) @(negedge clk);
      chk("t2_idle", {a_busy, a_done, a_htrans}, 0);
      chk("t2_code", a_code, 0);

      // Fail code, bus stalls and a sink stall on word 2.
      do_reset(3, -1, 1);
      push_words(4, 1'b1);
      ahb_write(TOHOST, HSIZE_WORD, 32'h5, ha, hb);
      chk("t3_hit", ha, 1);
      wait_done("t3_done", 600);
      chk("t3_code_pass", {a_code, a_pass}, {32'h5, 1'b0});
      chk("t3_words", acc_cnt, 4);
      chk("t3_queue_empty", exp_q.size(), 0);
      chk("t3_stall_seen", rwait, 10);

      // A later exit write is ignored.
      ahb_write(TOHOST, HSIZE_WORD, 32'h1, ha, hb);
      chk("t6_no_hit", ha, 0);
      @(negedge clk);
      chk("t6_code_frozen", {a_code, a_pass, a_done}, {32'h5, 2'b01});

      // Error response on the third read.
      do_reset(0, 2, -1);
      push_words(2, 1'b0);
      ahb_write(TOHOST, HSIZE_WORD, 32'h1, ha, hb);
      chk("t4_hit", ha, 1);
      wait_done("t4_done", 200);
      chk("t4_err", a_err, 1);
      chk("t4_words", acc_cnt, 2);
      chk("t4_queue_empty", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      chk("t4_quiet", {a_valid, a_busy, a_htrans}, 0);

      // Reset in the middle of a dump.
      do_reset(0, -1, -1);
      push_words(4, 1'b1);
      ahb_write(TOHOST, HSIZE_WORD, 32'h1, ha, hb);
      begin
         int n = 0;
         while (!a_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
      end
      chk("t5_valid_seen", a_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_flags",
          {a_valid, a_last, a_hit, a_pass, a_busy, a_done, a_err,
           a_htrans},
          {7'b0, HTRANS_IDLE});
      chk("t5_haddr_data", {a_haddr, a_data}, 0);
      chk("t5_code", a_code, 0);
      exp_q.delete();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
